// File: rtl/if_byte_fetch_pkg.sv
// -----------------------------------------------------------------------------
// riscv_defs
//   Definitions shared by the instruction-fetch stage and its helpers.
//   - fetch_state_t : fetch FSM states (IDLE / READ / HOLD)
//   - INST_W        : instruction width in bits
//   - INST_BYTES    : bytes fetched per instruction
//   - BYTE_W        : width of one RAM word
// -----------------------------------------------------------------------------
package riscv_defs;

    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;
    localparam int BYTE_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage : riscv_defs

// File: rtl/if_byte_fetch_if.sv
// -----------------------------------------------------------------------------
// if_byte_fetch_if
//   Bundles the three handshakes around the fetch stage:
//   - request  : req_valid / req_addr / req_ready
//   - control  : flush
//   - decoder  : inst_valid / inst / inst_addr / inst_ready
//   - RAM      : mem_ce / mem_addr / mem_din (registered read, 1-cycle latency)
//   Modports:
//   - slave  : the fetch stage itself
//   - master : the surroundings (PC logic, decoder, RAM)
// -----------------------------------------------------------------------------
interface if_byte_fetch_if #(
    parameter int ADDR_W = 17
);
    import riscv_defs::*;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              flush;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ready;
    logic              mem_ce;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_din;

    modport slave (
        input  req_valid, req_addr, flush, inst_ready, mem_din,
        output req_ready, inst_valid, inst, inst_addr, mem_ce, mem_addr
    );

    modport master (
        output req_valid, req_addr, flush, inst_ready, mem_din,
        input  req_ready, inst_valid, inst, inst_addr, mem_ce, mem_addr
    );

endinterface : if_byte_fetch_if

// File: rtl/if_byte_fetch_cache.sv
// -----------------------------------------------------------------------------
// if_last_inst_cache
//   Single-entry {address, instruction, valid} store of the last instruction
//   assembled from RAM. Only built when IF_LAST_INST_CACHE_EN is defined.
//   Ports:
//   - clk, rst_n      : clock, async active-low reset (clears the entry)
//   - i_flush         : clears the entry (wins over a write in the same cycle)
//   - i_wr_en         : write {i_wr_addr, i_wr_inst} and mark valid
//   - i_lookup_addr   : address to compare against the entry
//   - o_hit / o_inst  : combinational hit flag and stored instruction
// -----------------------------------------------------------------------------
`ifdef IF_LAST_INST_CACHE_EN
module if_last_inst_cache
    import riscv_defs::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [INST_W-1:0] i_wr_inst,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [INST_W-1:0] o_inst
);
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [INST_W-1:0] r_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_inst  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_addr  <= i_wr_addr;
            r_inst  <= i_wr_inst;
        end
    end

    assign o_hit  = r_valid & (r_addr == i_lookup_addr);
    assign o_inst = r_inst;

endmodule : if_last_inst_cache
`endif

// File: rtl/if_byte_fetch.sv
// -----------------------------------------------------------------------------
// if_byte_fetch
//   Instruction-fetch stage: accepts one request at a time, reads four
//   consecutive bytes from a byte-wide registered-read RAM and presents them
//   little-endian as a 32-bit instruction under a valid/ready handshake.
//   Ports:
//   - clk, rst_n : clock (rising edge), async active-low reset
//   - io_fb      : if_byte_fetch_if.slave (request, flush, decoder, RAM)
//   Timing: accept at E0, mem_ce in cycles 1-4, bytes captured at E2-E5,
//   inst_valid from cycle 6.
//   Optional feature: define IF_LAST_INST_CACHE_EN to add a one-entry cache
//   of the last fetched instruction; a hit goes straight to HOLD (valid in
//   cycle 1, no RAM traffic).
// -----------------------------------------------------------------------------
module if_byte_fetch
    import riscv_defs::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic           clk,
    input  logic           rst_n,
    if_byte_fetch_if.slave io_fb
);
    fetch_state_t      r_state;
    fetch_state_t      w_next;

    logic [ADDR_W-1:0] r_inst_addr;
    logic [INST_W-1:0] r_inst;
    logic              r_mem_ce;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_ce_d;       // a RAM byte is on mem_din this cycle
    logic [2:0]        r_issue;      // bytes issued so far (0..INST_BYTES)
    logic [1:0]        r_cap;        // next byte lane to capture

    logic              w_req_ready;
    logic              w_inst_valid;
    logic              w_accept;
    logic              w_capture;
    logic              w_last_cap;
    logic              w_hit;
    logic [INST_W-1:0] w_hit_inst;

    // flush is folded into req_ready, so nothing is accepted in a flush cycle
    assign w_accept   = io_fb.req_valid & w_req_ready;
    // Capture is gated by READ so that bytes arriving after a flush or
    // reset-abort are never written into the instruction.
    assign w_capture  = (r_state == READ) & r_ce_d;
    assign w_last_cap = w_capture & (r_cap == 2'(INST_BYTES - 1));

`ifdef IF_LAST_INST_CACHE_EN
    if_last_inst_cache #(
        .ADDR_W (ADDR_W)
    ) u_cache (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (io_fb.flush),
        .i_wr_en       (w_last_cap & ~io_fb.flush),
        .i_wr_addr     (r_inst_addr),
        .i_wr_inst     ({io_fb.mem_din, r_inst[INST_W-BYTE_W-1:0]}),
        .i_lookup_addr (io_fb.req_addr),
        .o_hit         (w_hit),
        .o_inst        (w_hit_inst)
    );
`else
    assign w_hit      = 1'b0;
    assign w_hit_inst = '0;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_hit ? HOLD : READ;
            READ: if (w_last_cap) w_next = HOLD;
            HOLD: if (io_fb.inst_ready)
                      w_next = w_accept ? (w_hit ? HOLD : READ) : IDLE;
            default: w_next = IDLE;
        endcase
        if (io_fb.flush) w_next = IDLE;
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_req_ready  = ((r_state == IDLE) | ((r_state == HOLD) & io_fb.inst_ready))
                       & ~io_fb.flush;
        w_inst_valid = (r_state == HOLD);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_addr <= '0;
            r_inst      <= '0;
            r_mem_ce    <= 1'b0;
            r_mem_addr  <= '0;
            r_ce_d      <= 1'b0;
            r_issue     <= '0;
            r_cap       <= '0;
        end else if (io_fb.flush) begin
            // drop the RAM read in progress, including the byte in flight
            r_mem_ce <= 1'b0;
            r_ce_d   <= 1'b0;
        end else begin
            r_ce_d   <= r_mem_ce;
            r_mem_ce <= 1'b0;
            if (w_accept) begin
                r_inst_addr <= io_fb.req_addr;
                r_cap       <= '0;
                if (w_hit) begin
                    r_inst  <= w_hit_inst;
                    r_issue <= 3'(INST_BYTES);
                end else begin
                    // byte 0 is issued on the accept edge itself
                    r_mem_ce   <= 1'b1;
                    r_mem_addr <= io_fb.req_addr;
                    r_issue    <= 3'd1;
                end
            end else if ((r_state == READ) && (r_issue != 3'(INST_BYTES))) begin
                // address arithmetic wraps naturally at 2^ADDR_W
                r_mem_ce   <= 1'b1;
                r_mem_addr <= r_inst_addr + ADDR_W'(r_issue);
                r_issue    <= r_issue + 3'd1;
            end
            if (w_capture) begin
                r_inst[{r_cap, 3'b000} +: BYTE_W] <= io_fb.mem_din;
                r_cap                             <= r_cap + 2'd1;
            end
        end
    end

    assign io_fb.req_ready  = w_req_ready;
    assign io_fb.inst_valid = w_inst_valid;
    assign io_fb.inst       = r_inst;
    assign io_fb.inst_addr  = r_inst_addr;
    assign io_fb.mem_ce     = r_mem_ce;
    assign io_fb.mem_addr   = r_mem_addr;

endmodule : if_byte_fetch

// File: tb/tb_if_byte_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_byte_fetch
//   Directed and randomized bench for if_byte_fetch. The RAM is a plain byte
//   array with a one-cycle registered read. Expected instructions are built
//   directly from the array contents; expected latency and RAM traffic come
//   from whether the address should hit the last-instruction entry (only when
//   IF_LAST_INST_CACHE_EN is defined).
// -----------------------------------------------------------------------------
module tb_if_byte_fetch;
    localparam int AW  = 17;
    localparam int TOP = (1 << AW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    if_byte_fetch_if #(.ADDR_W(AW)) fb ();

    if_byte_fetch #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_fb (fb)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:TOP];
    always @(posedge clk) if (fb.mem_ce) fb.mem_din <= ram[fb.mem_addr];

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    // last-instruction entry as the bench expects it
    bit          cv = 1'b0;
    logic [AW-1:0] ca = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_inst(input logic [AW-1:0] a);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < 4; j++)
            v[8*j +: 8] = ram[(int'(a) + j) % (TOP + 1)];
        return v;
    endfunction

    function automatic bit model_hit(input logic [AW-1:0] a);
`ifdef IF_LAST_INST_CACHE_EN
        return cv && (ca == a);
`else
        return (a != a);
`endif
    endfunction

    // Present a request (optionally with inst_ready for a same-cycle
    // handshake), then follow it until inst_valid, checking RAM traffic.
    task automatic go(input logic [AW-1:0] a, input bit chained);
        bit hit;
        int lat;
        int nce;
        hit = model_hit(a);
        fb.req_valid = 1'b1;
        fb.req_addr  = a;
        if (chained) fb.inst_ready = 1'b1;
        #1;
        chk("req_ready", fb.req_ready, 1);
        tick;
        fb.req_valid  = 1'b0;
        fb.inst_ready = 1'b0;
        lat = 0;
        nce = 0;
        for (int c = 1; c <= 12; c++) begin
            if (fb.mem_ce) begin
                chk("mem_addr", fb.mem_addr, (int'(a) + nce) % (TOP + 1));
                chk("ce_cycle", c, nce + 1);
                nce++;
            end
            if (fb.inst_valid) begin
                lat = c;
                break;
            end
            tick;
        end
        chk("latency", lat, hit ? 1 : 6);
        chk("mem_ce_count", nce, hit ? 0 : 4);
        chk("inst", fb.inst, ref_inst(a));
        chk("inst_addr", fb.inst_addr, a);
        if (!hit) begin
            cv = 1'b1;
            ca = a;
        end
    endtask

    task automatic consume;
        fb.inst_ready = 1'b1;
        #1;
        chk("valid_before_take", fb.inst_valid, 1);
        tick;
        fb.inst_ready = 1'b0;
        chk("valid_after_take", fb.inst_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] cur;
        logic [AW-1:0] nxt;
        fb.req_valid  = 1'b0;
        fb.req_addr   = '0;
        fb.flush      = 1'b0;
        fb.inst_ready = 1'b0;
        for (int i = 0; i <= TOP; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;

        // reset state
        #2;
        chk("rst_inst_valid", fb.inst_valid, 0);
        chk("rst_mem_ce", fb.mem_ce, 0);
        chk("rst_inst", fb.inst, 0);
        chk("rst_inst_addr", fb.inst_addr, 0);
        chk("rst_mem_addr", fb.mem_addr, 0);
        chk("rst_req_ready", fb.req_ready, 1);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // single fetch of the known instruction
        go(0, 1'b0);
        chk("inst_known", fb.inst, 32'h00100513);

        // backpressure: held instruction stays put, nothing new starts
        for (int i = 0; i < 5; i++) begin
            fb.req_valid = 1'b1;
            fb.req_addr  = 4;
            #1;
            chk("bp_req_ready", fb.req_ready, 0);
            chk("bp_mem_ce", fb.mem_ce, 0);
            chk("bp_valid", fb.inst_valid, 1);
            chk("bp_inst", fb.inst, 32'h00100513);
            tick;
        end
        go(4, 1'b1);
        consume;

        // same address again: hit only when the entry exists
        go(4, 1'b0);
        consume;

        // flush while idle empties the entry
        fb.flush = 1'b1;
        tick;
        fb.flush = 1'b0;
        cv = 1'b0;
        go(4, 1'b0);
        consume;

        // wrap at the top of memory
        go(AW'(TOP - 1), 1'b0);
        consume;

        // flush in cycle 3 of a READ, with a request that must be ignored
        fb.req_valid = 1'b1;
        fb.req_addr  = 20;
        tick;
        fb.req_valid = 1'b0;
        tick;
        tick;
        fb.flush     = 1'b1;
        fb.req_valid = 1'b1;
        fb.req_addr  = 8;
        #1;
        chk("flush_req_ready", fb.req_ready, 0);
        tick;
        fb.flush     = 1'b0;
        fb.req_valid = 1'b0;
        cv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("flush_mem_ce", fb.mem_ce, 0);
            chk("flush_valid", fb.inst_valid, 0);
            tick;
        end
        go(8, 1'b0);
        consume;

        // asynchronous reset while holding an instruction
        go(12, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hold_valid", fb.inst_valid, 0);
        chk("arst_hold_mem_ce", fb.mem_ce, 0);
        chk("arst_hold_inst", fb.inst, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cv = 1'b0;
        tick;
        go(12, 1'b0);
        consume;

        // asynchronous reset in the middle of a READ
        fb.req_valid = 1'b1;
        fb.req_addr  = 36;
        tick;
        fb.req_valid = 1'b0;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_read_mem_ce", fb.mem_ce, 0);
        chk("arst_read_valid", fb.inst_valid, 0);
        chk("arst_read_inst", fb.inst, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cv = 1'b0;
        tick;
        for (int i = 0; i < 8; i++) begin
            chk("post_arst_valid", fb.inst_valid, 0);
            chk("post_arst_mem_ce", fb.mem_ce, 0);
            tick;
        end

        // randomized sequence of fetches, stalls and chained handshakes
        cur = AW'($urandom_range(0, TOP));
        go(cur, 1'b0);
        for (int n = 0; n < 14; n++) begin
            int stall;
            int pick;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                chk("rnd_hold_valid", fb.inst_valid, 1);
                chk("rnd_hold_inst", fb.inst, ref_inst(cur));
                chk("rnd_hold_mem_ce", fb.mem_ce, 0);
                tick;
            end
            pick = $urandom_range(0, 3);
            if (pick == 0)      nxt = cur;
            else if (pick == 1) nxt = AW'(TOP - $urandom_range(0, 3));
            else                nxt = AW'($urandom_range(0, TOP));
            if ($urandom_range(0, 1) == 1) begin
                go(nxt, 1'b1);
            end else begin
                consume;
                go(nxt, 1'b0);
            end
            cur = nxt;
        end
        consume;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule : tb_if_byte_fetch

// File: doc/if_byte_fetch.md
# if_byte_fetch

Instruction-fetch stage between the PC/request logic and the decoder. Takes one fetch request at a time, reads four consecutive bytes from the byte-wide program RAM, and assembles them little-endian into a 32-bit instruction. Presents the instruction to the decoder under a valid/ready handshake. The RAM has a registered read: data appears the cycle after `mem_ce` and `mem_addr` are presented.

## Interface
- `ADDR_W`, default 17: byte-address width for requests and RAM.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: fetch request present.
- `req_addr` in ADDR_W: byte address of the instruction.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `flush` in 1: abort current fetch and drop any held instruction.
- `inst_valid` out 1: `inst` and `inst_addr` are valid.
- `inst` out 32: assembled instruction.
- `inst_addr` out ADDR_W: address the instruction came from.
- `inst_ready` in 1: decoder consumes when `inst_valid & inst_ready`.
- `mem_ce` out 1: RAM read enable.
- `mem_addr` out ADDR_W: RAM byte address.
- `mem_din` in 8: RAM read data, registered, 1-cycle latency.

## Operation
- States: IDLE, READ, HOLD.
- Reset: state IDLE; `inst_valid`=0, `inst`=0, `inst_addr`=0, `mem_ce`=0, `mem_addr`=0; issue and capture counters at 0.
- `req_ready` is combinational: `(IDLE | (HOLD & inst_ready)) & !flush`. It reads 1 while in reset, but no state changes until `rst_n` rises.
- IDLE→READ on accept. Latch `req_addr` into `inst_addr`.
- READ:
  - Issue counter k=0..3 drives `mem_ce`=1 and `mem_addr`=`inst_addr`+k, taken mod 2^ADDR_W (wraps at top of memory).
  - Capture counter lags issue by one cycle. Byte j goes to `inst[8j+7:8j]`.
  - After byte 3 is captured: state→HOLD, `inst_valid`=1.
- HOLD:
  - `inst`, `inst_addr` and `inst_valid` stay stable until a handshake.
  - Handshake with no new accept: →IDLE, `inst_valid`=0.
  - Handshake plus accept in the same cycle: →READ directly, `inst_valid`=0, new address latched.
- `mem_ce`=0 in every cycle that does not issue a byte.
- `flush` has priority over everything: next state IDLE, `inst_valid`=0, `mem_ce`=0.
  - Bytes still in flight from the RAM are ignored.
  - A request presented in the flush cycle is not accepted.
- Low two bits of `req_addr` are used as given. No alignment check.

## Timing
- Accept on edge E0. `mem_ce`=1 in cycles 1–4 with addresses A, A+1, A+2, A+3.
- Bytes are visible on `mem_din` in cycles 2–5 and captured at edges E2–E5.
- `inst_valid` rises in cycle 6: accept-to-valid latency is 6 cycles.
- Back-to-back with `inst_ready` held at 1: one instruction every 6 cycles.
- `rst_n` asserted mid-READ: all outputs clear immediately (asynchronously). No partial instruction is ever presented.

## Configuration
- Macro `IF_LAST_INST_CACHE_EN`.
- Defined: adds a single-entry cache of {address, instruction, valid}.
  - Entry is written when READ completes.
  - Entry is cleared by reset and by `flush`.
  - An accepted request whose address equals the cached address goes straight to HOLD. `inst_valid` rises in cycle 1 with the cached instruction, and `mem_ce` stays 0.
- Undefined: every request performs the 4-byte RAM read.

## Structure
- Shared package `riscv_defs`:
  - state enum {IDLE, READ, HOLD};
  - `INST_W`=32;
  - `INST_BYTES`=4.
- Optional sub-module `if_last_inst_cache`: holds the entry, does the compare, and is instantiated only under the macro. Everything else stays in one module.

## Test plan
- Single fetch: RAM[0..3]=13,05,10,00; request addr 0 → `mem_ce` high cycles 1–4 at addresses 0–3; `inst`=0x00100513 with `inst_valid` in cycle 6.
- Backpressure: hold `inst_ready`=0 for 5 cycles → `inst` stable, `req_ready`=0, no `mem_ce`; on `inst_ready`=1 plus a request at addr 4 in the same cycle → handshake, and the new fetch starts the next cycle.
- Wrap: request addr 2^ADDR_W−2 → `mem_addr` sequence top−1, top, 0, 1; bytes assembled in that order.
- Flush in cycle 3 of READ → `mem_ce`=0 from cycle 4; `inst_valid` never rises; a new request at addr 8 produces only addr-8 data.
- Async reset in HOLD → `inst_valid`, `mem_ce`, `inst` = 0 before the next edge; a fresh fetch afterwards has 6-cycle latency.
- With `IF_LAST_INST_CACHE_EN`: fetch addr 0, consume, re-request addr 0 → `inst_valid` in cycle 1, no `mem_ce`; after a `flush` the same request takes 6 cycles.
